// File: rtl/nn_pkg.sv
// Shared constants and types for the MNIST front end.
// Frame geometry and collector state encoding.
package nn_pkg;

  localparam int IMG_WIDTH     = 28;
  localparam int IMG_HEIGHT    = 28;
  localparam int PIXELS_NUMBER = IMG_WIDTH * IMG_HEIGHT;
  localparam int POOLED_PIXELS = PIXELS_NUMBER / 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/pixel_frame_collector_if.sv
// Raster pixel stream with valid/ready handshake.
// master drives pixels, slave is the collector.
interface pixel_stream_if #(
  parameter int resolution = 8
) ();

  logic [resolution-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_sof;
  logic                  pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_sof,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    input  pix_sof,
    output pix_ready
  );

endinterface

// File: rtl/frame_index_counter.sv
// Raster write index for the frame collector.
// Priority: clear, load-1 (restart), increment.
module frame_index_counter #(
  parameter int pixels_number = 784,
  parameter int idx_w         = $clog2(pixels_number)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             load1,
  input  logic             clr,
  output logic [idx_w-1:0] idx,
  output logic             tc
);

  assign tc = (idx == idx_w'(pixels_number - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load1) begin
      idx <= idx_w'(1);
    end else if (inc) begin
      idx <= idx + idx_w'(1);
    end
  end

endmodule

// File: rtl/pixel_frame_collector.sv
// Collects one raster-order frame into a flat bus
// and holds it until the consumer acknowledges.
module pixel_frame_collector
  import nn_pkg::*;
#(
  parameter  int resolution    = 8,
  parameter  int img_width     = IMG_WIDTH,
  parameter  int img_height    = IMG_HEIGHT,
  localparam int pixels_number = img_width * img_height,
  localparam int idx_w         = $clog2(pixels_number)
) (
  input  logic                                clk,
  input  logic                                reset,
  pixel_stream_if.slave                       pix,
  input  logic                                frame_ack,
  output logic [resolution*pixels_number-1:0] pixels,
  output logic                                frame_valid,
  output logic                                sof_restart
);

  state_t state_q, state_d;

  logic             beat;
  logic             sof_beat;
  logic             last_beat;
  logic             tc;
  logic [idx_w-1:0] idx;

  logic [resolution-1:0] mem [0:pixels_number-1];

  assign pix.pix_ready = (state_q == FILL);
  assign beat      = pix.pix_valid & (state_q == FILL);
  assign sof_beat  = beat & pix.pix_sof;
  // a sof on the terminal beat restarts instead of completing
  assign last_beat = beat & ~pix.pix_sof & tc;

  frame_index_counter #(
    .pixels_number (pixels_number),
    .idx_w         (idx_w)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .inc   (beat & ~pix.pix_sof & ~tc),
    .load1 (sof_beat),
    .clr   (last_beat),
    .idx   (idx),
    .tc    (tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (last_beat) state_d = HOLD;
      HOLD: if (frame_ack) state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      frame_valid <= 1'b0;
      sof_restart <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_valid <= (state_d == HOLD);
      sof_restart <= sof_beat & (idx != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < pixels_number; i++) begin
        mem[i] <= '0;
      end
    end else if (beat) begin
      mem[sof_beat ? idx_w'(0) : idx] <= pix.pix_data;
    end
  end

  for (genvar g = 0; g < pixels_number; g++) begin : g_flat
    assign pixels[g*resolution +: resolution] = mem[g];
  end

endmodule
